// File: rtl/mem_port_arbiter_pkg.sv
// Encodings shared by the unified memory port arbiter and the hazard-unit checks.
package mem_port_arbiter_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // A zero timeout still needs a one-bit counter to keep the port widths legal.
  function automatic int cntWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            iReq;
  logic [XLEN-1:0] iAddr;
  logic            iKill;
  logic [XLEN-1:0] iRdata;
  logic            iReady;
  logic            dReq;
  logic            dWe;
  logic [XLEN-1:0] dAddr;
  logic [XLEN-1:0] dWdata;
  logic [3:0]      dBe;
  logic [XLEN-1:0] dRdata;
  logic            dReady;
  logic            mReq;
  logic            mWe;
  logic [XLEN-1:0] mAddr;
  logic [XLEN-1:0] mWdata;
  logic [3:0]      mBe;
  logic [XLEN-1:0] mRdata;
  logic            mReady;
  logic            stallF;
  logic            stallM;
  logic            timeoutErr;

  modport slave (
    input  iReq, iAddr, iKill, dReq, dWe, dAddr, dWdata, dBe, mRdata, mReady,
    output iRdata, iReady, dRdata, dReady, mReq, mWe, mAddr, mWdata, mBe,
           stallF, stallM, timeoutErr
  );

  modport master (
    output iReq, iAddr, iKill, dReq, dWe, dAddr, dWdata, dBe, mRdata, mReady,
    input  iRdata, iReady, dRdata, dReady, mReq, mWe, mAddr, mWdata, mBe,
           stallF, stallM, timeoutErr
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Counts cycles spent waiting on the memory and raises a sticky error at the limit.
module mem_port_arbiter_timeout #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic timeoutErr
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;
  logic             hitLimit;

  // The flag rises on the same edge the count reaches the limit; a zero limit never fires.
  assign hitLimit = (TIMEOUT != 0) && enable && (count == LIMIT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable && (count != LIMIT)) begin
        count <= count + CNT_W'(1);
      end
      if (hitLimit) begin
        timeoutErr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and memory stages, data side first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = cntWidth(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  arbState_e state;
  logic      killFlag;
  logic      waiting;
  logic      timeoutErr;

  assign waiting        = ((state == BUSY_I) || (state == BUSY_D)) && !bus.mReady;
  assign bus.stallF     = bus.iReq & ~bus.iReady;
  assign bus.stallM     = bus.dReq & ~bus.dReady;
  assign bus.timeoutErr = timeoutErr;

  mem_port_arbiter_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) timeoutCounter (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (waiting),
    .clear      (state == IDLE),
    .timeoutErr (timeoutErr)
  );

  // Grants only from IDLE, so a request still held during RESP is never issued twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      killFlag   <= 1'b0;
      bus.mReq   <= 1'b0;
      bus.mWe    <= 1'b0;
      bus.mAddr  <= '0;
      bus.mWdata <= '0;
      bus.mBe    <= '0;
      bus.iRdata <= '0;
      bus.iReady <= 1'b0;
      bus.dRdata <= '0;
      bus.dReady <= 1'b0;
    end else begin
      bus.iReady <= 1'b0;
      bus.dReady <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dReq) begin
            state      <= BUSY_D;
            bus.mReq   <= 1'b1;
            bus.mWe    <= bus.dWe;
            bus.mAddr  <= bus.dAddr;
            bus.mWdata <= bus.dWdata;
            bus.mBe    <= bus.dBe;
          end else if (bus.iReq) begin
            state      <= BUSY_I;
            bus.mReq   <= 1'b1;
            bus.mWe    <= 1'b0;
            bus.mAddr  <= bus.iAddr;
            bus.mWdata <= '0;
            bus.mBe    <= 4'hF;
          end
        end
        BUSY_I: begin
          if (bus.iKill) begin
            killFlag <= 1'b1;
          end
          // A kill arriving together with the memory response still drops the fetch.
          if (bus.mReady) begin
            state      <= RESP;
            bus.mReq   <= 1'b0;
            bus.iRdata <= bus.mRdata;
            bus.iReady <= !(killFlag || bus.iKill);
          end
        end
        BUSY_D: begin
          if (bus.mReady) begin
            state      <= RESP;
            bus.mReq   <= 1'b0;
            bus.dRdata <= bus.mRdata;
            bus.dReady <= 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          killFlag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding access, then one response cycle, then the port is free.
  logic        mdlBusy;
  logic        mdlRespNow;
  logic        mdlRespI;
  logic        mdlRespDrop;
  logic        mdlKilled;
  logic        mdlErr;
  logic        mdlTxIsI;
  logic        mdlTxWe;
  logic [31:0] mdlTxAddr;
  logic [31:0] mdlTxWdata;
  logic [3:0]  mdlTxBe;
  logic [31:0] mdlIData;
  logic [31:0] mdlDData;
  int          mdlWait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdlBusy     <= 1'b0;
      mdlRespNow  <= 1'b0;
      mdlRespI    <= 1'b0;
      mdlRespDrop <= 1'b0;
      mdlKilled   <= 1'b0;
      mdlErr      <= 1'b0;
      mdlTxIsI    <= 1'b0;
      mdlTxWe     <= 1'b0;
      mdlTxAddr   <= '0;
      mdlTxWdata  <= '0;
      mdlTxBe     <= '0;
      mdlIData    <= '0;
      mdlDData    <= '0;
      mdlWait     <= 0;
    end else if (mdlRespNow) begin
      mdlRespNow <= 1'b0;
    end else if (mdlBusy) begin
      if (bus.mReady) begin
        mdlBusy     <= 1'b0;
        mdlRespNow  <= 1'b1;
        mdlRespI    <= mdlTxIsI;
        mdlRespDrop <= mdlTxIsI && (mdlKilled || bus.iKill);
        if (mdlTxIsI) mdlIData <= bus.mRdata;
        else          mdlDData <= bus.mRdata;
      end else begin
        if (mdlTxIsI && bus.iKill) mdlKilled <= 1'b1;
        if (mdlWait < TB_TIMEOUT) mdlWait <= mdlWait + 1;
        if (mdlWait == TB_TIMEOUT - 1) mdlErr <= 1'b1;
      end
    end else begin
      mdlKilled <= 1'b0;
      mdlWait   <= 0;
      if (bus.dReq) begin
        mdlBusy    <= 1'b1;
        mdlTxIsI   <= 1'b0;
        mdlTxWe    <= bus.dWe;
        mdlTxAddr  <= bus.dAddr;
        mdlTxWdata <= bus.dWdata;
        mdlTxBe    <= bus.dBe;
      end else if (bus.iReq) begin
        mdlBusy   <= 1'b1;
        mdlTxIsI  <= 1'b1;
        mdlTxWe   <= 1'b0;
        mdlTxAddr <= bus.iAddr;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic iKill,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [3:0] dBe,
                               input logic mReady, input logic [31:0] mRdata);
    bus.iReq   = iReq;
    bus.iAddr  = iAddr;
    bus.iKill  = iKill;
    bus.dReq   = dReq;
    bus.dWe    = dWe;
    bus.dAddr  = dAddr;
    bus.dWdata = dWdata;
    bus.dBe    = dBe;
    bus.mReady = mReady;
    bus.mRdata = mRdata;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expIReady;
    logic expDReady;
    bus.iReq   = 1'b0;
    bus.iAddr  = '0;
    bus.iKill  = 1'b0;
    bus.dReq   = 1'b0;
    bus.dWe    = 1'b0;
    bus.dAddr  = '0;
    bus.dWdata = '0;
    bus.dBe    = '0;
    bus.mReady = 1'b0;
    bus.mRdata = '0;
    fork
      forever begin
        @(negedge clk);
        expIReady = mdlRespNow && mdlRespI && !mdlRespDrop;
        expDReady = mdlRespNow && !mdlRespI;
        checkOutput("cmp_mReq", 32'(bus.mReq), 32'(mdlBusy));
        checkOutput("cmp_iReady", 32'(bus.iReady), 32'(expIReady));
        checkOutput("cmp_dReady", 32'(bus.dReady), 32'(expDReady));
        checkOutput("cmp_stallF", 32'(bus.stallF), 32'(bus.iReq & ~expIReady));
        checkOutput("cmp_stallM", 32'(bus.stallM), 32'(bus.dReq & ~expDReady));
        checkOutput("cmp_timeoutErr", 32'(bus.timeoutErr), 32'(mdlErr));
        if (mdlBusy) begin
          checkOutput("cmp_mAddr", bus.mAddr, mdlTxAddr);
          checkOutput("cmp_mWe", 32'(bus.mWe), 32'(mdlTxWe));
          if (!mdlTxIsI) begin
            checkOutput("cmp_mWdata", bus.mWdata, mdlTxWdata);
            checkOutput("cmp_mBe", 32'(bus.mBe), 32'(mdlTxBe));
          end
        end
        if (expIReady) checkOutput("cmp_iRdata", bus.iRdata, mdlIData);
        if (expDReady) checkOutput("cmp_dRdata", bus.dRdata, mdlDData);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_mReq", 32'(bus.mReq), 32'h0);
        checkOutput("rst_iReady", 32'(bus.iReady), 32'h0);
        checkOutput("rst_dReady", 32'(bus.dReady), 32'h0);
        checkOutput("rst_timeoutErr", 32'(bus.timeoutErr), 32'h0);
        rst_n = 1'b1;
        idleCycle();
        // Stray memory completion while idle must not produce a response.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFF0000);
        checkOutput("stray_dReady", 32'(bus.dReady), 32'h0);
        checkOutput("stray_iReady", 32'(bus.iReady), 32'h0);

        // Plain fetch; a kill during IDLE has no effect.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("t1_mReq", 32'(bus.mReq), 32'h1);
        checkOutput("t1_mAddr", bus.mAddr, 32'h100);
        checkOutput("t1_stallF", 32'(bus.stallF), 32'h1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093);
        checkOutput("t1_iReady", 32'(bus.iReady), 32'h1);
        checkOutput("t1_iRdata", bus.iRdata, 32'h00500093);
        checkOutput("t1_stallF_done", 32'(bus.stallF), 32'h0);
        idleCycle();
        checkOutput("t1_pulse_once", 32'(bus.iReady), 32'h0);

        // Simultaneous requests: the store goes first, the fetch after its RESP.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        checkOutput("t2_mWe", 32'(bus.mWe), 32'h1);
        checkOutput("t2_mAddr", bus.mAddr, 32'h2000);
        checkOutput("t2_mWdata", bus.mWdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
        checkOutput("t2_dReady", 32'(bus.dReady), 32'h1);
        checkOutput("t2_stallF", 32'(bus.stallF), 32'h1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("t2_no_grant_in_resp", 32'(bus.mReq), 32'h0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("t2_i_granted", 32'(bus.mReq), 32'h1);
        checkOutput("t2_i_addr", bus.mAddr, 32'h200);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00000013);
        checkOutput("t2_iRdata", bus.iRdata, 32'h00000013);
        idleCycle();

        // Killed fetch: access completes but no response pulse.
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00A00113);
        checkOutput("t3_iReady_killed", 32'(bus.iReady), 32'h0);
        idleCycle();
        checkOutput("t3_state_idle", 32'(dut.state), 32'(IDLE));

        // Slow load: request fields stay stable while the memory stalls.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h3, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
          checkOutput("t4_mAddr_stable", bus.mAddr, 32'h3000);
          checkOutput("t4_mBe_stable", 32'(bus.mBe), 32'h3);
          applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h3, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h3, 1'b1, 32'h12345678);
        checkOutput("t4_dReady", 32'(bus.dReady), 32'h1);
        checkOutput("t4_dRdata", bus.dRdata, 32'h12345678);
        checkOutput("t4_no_timeout", 32'(bus.timeoutErr), 32'h0);
        idleCycle();

        // Memory never answers: sticky error after TB_TIMEOUT waiting cycles.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4000, 32'h11, 4'h1, 1'b0, 32'h0);
        for (int k = 1; k <= TB_TIMEOUT + 2; k++) begin
          applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4000, 32'h11, 4'h1, 1'b0, 32'h0);
          checkOutput("t5_timeoutErr", 32'(bus.timeoutErr), (k >= TB_TIMEOUT) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset in the middle of the stuck store.
        rst_n = 1'b0;
        #1;
        checkOutput("t6_mReq", 32'(bus.mReq), 32'h0);
        checkOutput("t6_dReady", 32'(bus.dReady), 32'h0);
        checkOutput("t6_iReady", 32'(bus.iReady), 32'h0);
        checkOutput("t6_timeoutErr", 32'(bus.timeoutErr), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h0);
        checkOutput("t6_regrant", 32'(bus.mReq), 32'h1);
        checkOutput("t6_regrant_addr", bus.mAddr, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D);
        checkOutput("t6_dRdata", bus.dRdata, 32'hCAFEF00D);
        repeat (2) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
